mmio_uart_tx: RTL and testbench
===============================

Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the core's data-memory bus, downstream of the single-cycle RISC-V core.
- Consumes the core's store traffic (memWrite, dataAdr, writeData) and returns status on readData through the top-level data mux.
- Buffers bytes in a small FIFO and serialises them as 8N1 frames on a TX pin.

Parameters:
- BASE_ADDR, 32'h1000_0000, word-aligned base of the 16-byte register window (BASE_ADDR[3:0] must be 0).
- FIFO_DEPTH, 8, TX FIFO entries; power of two, at least 2.
- CLKS_PER_BIT, 16, reset value of the baud divisor (clocks per serial bit).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- memWrite  input  1  store strobe from the core.
- dataAdr  input  32  byte address from the core.
- writeData  input  32  store data from the core.
- sel  output  1  combinational; high when dataAdr hits this block's window.
- rdata  output  32  combinational read data; 0 when sel is low.
- tx  output  1  serial output; idles high.

Behaviour:
- Decode:
  - sel = (dataAdr[31:4] == BASE_ADDR[31:4]) and (dataAdr[1:0] == 0).
  - Register offset = dataAdr[3:2].
  - Writes take effect only when memWrite and sel are both high, at the rising edge.
- Register map:
  - 0x0 DATA, write-only. Pushes writeData[7:0] into the FIFO. Reads return 0.
  - 0x4 STATUS, read/write-1-to-clear.
    - Bit 0: busy (FSM not IDLE).
    - Bit 1: full.
    - Bit 2: empty.
    - Bit 3: overflow, sticky.
    - Bits [15:8]: FIFO count. All other bits 0.
    - Writing 1 to bit 3 clears overflow; all other written bits are ignored.
  - 0x8 DIV, read/write, 16 bits in rdata[15:0]. Written values below 2 are stored as 2.
  - 0xC reserved. Reads 0; writes ignored.
- Reset:
  - tx = 1; FSM = IDLE; FIFO empty (count 0).
  - overflow = 0; DIV = CLKS_PER_BIT.
  - Bit and clock counters = 0.
- FIFO:
  - Push when a DATA write occurs and (not full, or a pop occurs in the same cycle).
  - A push on a full FIFO with no pop that cycle is dropped and sets overflow. The FIFO is unchanged.
  - Simultaneous push and pop leaves the count unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is not empty, pop the head into the shift register, latch DIV into the active divisor, clear the clock counter, and go to START. Otherwise stay in IDLE.
  - START: tx = 0 for one divisor period, then go to DATA with bit index 0.
  - DATA: tx = shift[0] for one divisor period per bit, LSB first. Shift right after each bit. After bit 7, go to STOP.
  - STOP: tx = 1 for one divisor period. Then, if the FIFO is not empty, pop the next byte and go directly to START (back-to-back frames, no idle gap). Otherwise go to IDLE.
  - Divisor period: the clock counter runs 0 .. div-1. The state or bit advances on the edge where counter == div-1.
- Latency: a DATA write captured at edge N into an empty, idle block is popped at edge N+1. tx falls after edge N+1.
- Frame length is exactly 10 × div clocks. The start-bit falling edge of each frame is 10 × div clocks after the previous one when frames are back-to-back.
- A DIV write during a frame does not affect that frame; it applies from the next pop.
- rst asserted mid-frame: on the next edge tx returns high, the FIFO is flushed, and the FSM goes to IDLE. No partial frame completes.
- tx is driven from a register (glitch-free).

Test Plan:
- Reset, then write 0x55 to DATA with DIV = 4. Required: tx low for 4 clocks starting 1 cycle after the write edge, then 1,0,1,0,1,0,1,0 (4 clocks each), then high for 4 clocks. STATUS reads busy=1 during the frame and 0x0000_0004 (empty) afterwards.
- Write 0xA5, 0x3C, 0xFF in consecutive cycles with DIV = 2. Required: three back-to-back frames of 20 clocks each with no idle gap. STATUS count reads 2 right after the third write.
- Hold FSM busy and write 9 bytes with FIFO_DEPTH = 8 (first pops immediately). Required: 8 held, 9th accepted only if it coincides with a pop, otherwise overflow = 1. Writing 0x8 to STATUS clears overflow.
- Write DIV = 0 → reads back 2. Write DIV = 8 mid-frame → current frame keeps the old period; the next frame uses 8 clocks per bit.
- Access BASE+0xC, BASE+0x2, and BASE+0x10. Required: sel = 0 for 0x2 and 0x10, rdata = 0 for all three, and FIFO/DIV unchanged.
- Assert rst for 1 cycle during the DATA bits of a frame with 3 bytes queued. Required: tx = 1 and STATUS = 0x0000_0004 the next cycle, and no further frames.

Source files
------------

// File: rtl/mmio_uart_tx_if.sv
// Data-memory bus slice seen by the UART transmitter: core store traffic in,
// select and read data back out to the top-level data mux.
interface mmio_uart_tx_if;
  logic        memWrite;
  logic [31:0] dataAdr;
  logic [31:0] writeData;
  logic        sel;
  logic [31:0] rdata;

  modport master (output memWrite, dataAdr, writeData, input sel, rdata);
  modport slave  (input memWrite, dataAdr, writeData, output sel, rdata);
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: DATA/STATUS/DIV registers, a TX FIFO
// and a START/DATA/STOP serialiser that chains frames with no idle gap.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
  parameter int          FIFO_DEPTH   = 8,
  parameter int          CLKS_PER_BIT = 16
) (
  input  logic           clk,
  input  logic           rst,
  mmio_uart_tx_if.slave  bus,
  output logic           tx
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e          state_q, state_d;
  logic [15:0]     div_q, adiv_q, adiv_d, cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            ovf_q;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   count_q;

  logic [1:0]      off;
  logic            wr, data_wr, push, pop, full, empty, tick;
  logic [31:0]     status;
  logic            unused_wd;

  // Address decode: word-aligned hits inside the 16-byte window only
  assign bus.sel   = (bus.dataAdr[31:4] == BASE_ADDR[31:4]) && (bus.dataAdr[1:0] == 2'b00);
  assign off       = bus.dataAdr[3:2];
  assign wr        = bus.memWrite && bus.sel;
  assign data_wr   = wr && (off == 2'd0);
  assign unused_wd = ^bus.writeData[31:16];

  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign push  = data_wr && (!full || pop);
  assign tick  = (cnt_q == adiv_q - 16'd1);

  assign status = {16'd0, 8'(count_q), 4'd0, ovf_q, empty, full, state_q != S_IDLE};

  always_comb begin
    bus.rdata = '0;
    if (bus.sel) begin
      case (off)
        2'd1:    bus.rdata = status;
        2'd2:    bus.rdata = {16'd0, div_q};
        default: bus.rdata = '0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    adiv_d  = adiv_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rptr_q];
          adiv_d  = div_q;
          cnt_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else cnt_d = cnt_q + 16'd1;
      end
      S_DATA: begin
        if (tick) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else cnt_d = cnt_q + 16'd1;
      end
      S_STOP: begin
        if (tick) begin
          cnt_d = '0;
          // Chain straight into the next start bit when more data is queued
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rptr_q];
            adiv_d  = div_q;
            state_d = S_START;
          end else state_d = S_IDLE;
        end else cnt_d = cnt_q + 16'd1;
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      adiv_q  <= 16'(CLKS_PER_BIT);
      div_q   <= 16'(CLKS_PER_BIT);
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      adiv_q  <= adiv_d;
      tx_q    <= tx_d;
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
      if (data_wr && !push)                                 ovf_q <= 1'b1;
      else if (wr && (off == 2'd1) && bus.writeData[3])     ovf_q <= 1'b0;
      if (wr && (off == 2'd2))
        div_q <= (bus.writeData[15:0] < 16'd2) ? 16'd2 : bus.writeData[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= bus.writeData[7:0];
  end

  assign tx = tx_q;
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench: queued bytes are checked cycle-by-cycle on the tx pin by a
// frame monitor; register behaviour is checked inline in each test task.
module tb_mmio_uart_tx;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] A_DATA = BASE + 32'h0, A_STAT = BASE + 32'h4, A_DIV = BASE + 32'h8;

  typedef struct { logic [7:0] b; int div; } exp_t;

  logic clk = 1'b0, rst = 1'b1, tx;
  mmio_uart_tx_if bus();

  mmio_uart_tx #(.BASE_ADDR(BASE), .FIFO_DEPTH(8), .CLKS_PER_BIT(16)) dut (
    .clk(clk), .rst(rst), .bus(bus), .tx(tx));

  always #10 clk = ~clk;

  int   cyc = 0, checks = 0, errors = 0, frames_done = 0;
  bit   mon_abort = 1'b0;
  exp_t sb[$];
  int   starts[$];
  exp_t mon_e;
  logic expb;

  always @(posedge clk) cyc <= cyc + 1;

  // Frame monitor: every cycle of a frame is compared with the expected level
  initial begin
    forever begin
      @(negedge clk);
      if (!tx && !mon_abort && !rst) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_frame cycle=%0d tx=%b required idle 1", cyc, tx);
        end else begin
          mon_e = sb.pop_front();
          starts.push_back(cyc);
          for (int i = 0; i < 10 * mon_e.div; i++) begin
            if (i > 0) @(negedge clk);
            if (mon_abort) break;
            if (i < mon_e.div)           expb = 1'b0;
            else if (i >= 9 * mon_e.div) expb = 1'b1;
            else                         expb = mon_e.b[(i - mon_e.div) / mon_e.div];
            checks++;
            if (tx !== expb) begin
              errors++;
              $display("FAIL frame_bit byte=%h clk_in_frame=%0d tx=%b required=%b", mon_e.b, i, tx, expb);
            end
          end
          frames_done++;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    bus.memWrite = 1'b1; bus.dataAdr = a; bus.writeData = d;
    @(posedge clk); #1;
    bus.memWrite = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d, output logic s);
    bus.dataAdr = a; #1;
    d = bus.rdata; s = bus.sel;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames_done < target && n < budget) begin @(posedge clk); n++; end
    #1;
    checks++;
    if (frames_done < target) begin
      errors++;
      $display("FAIL frame_timeout frames=%0d required=%0d", frames_done, target);
    end
  endtask

  task automatic test_reset;
    logic [31:0] d; logic s;
    bus.memWrite = 1'b0; bus.dataAdr = '0; bus.writeData = '0;
    rst = 1'b1; tick(3); rst = 1'b0;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got=%b required=1", tx); end
    bus_rd(A_STAT, d, s);
    checks++; if (s !== 1'b1) begin errors++; $display("FAIL reset_sel got=%b required=1", s); end
    checks++; if (d !== 32'h4) begin errors++; $display("FAIL reset_status got=%h required=00000004", d); end
    bus_rd(A_DIV, d, s);
    checks++; if (d !== 32'd16) begin errors++; $display("FAIL reset_div got=%0d required=16", d); end
  endtask

  task automatic test_single;
    logic [31:0] d; logic s; int cn, f0;
    bus_wr(A_DIV, 32'd4);
    starts.delete(); f0 = frames_done;
    sb.push_back('{8'h55, 4});
    bus_wr(A_DATA, 32'h55);
    cn = cyc;
    tick(6);
    bus_rd(A_STAT, d, s);
    checks++; if (d !== 32'h5) begin errors++; $display("FAIL single_busy_status got=%h required=00000005", d); end
    wait_frames(f0 + 1, 100);
    checks++;
    if (starts.size() < 1 || starts[0] != cn + 1) begin
      errors++; $display("FAIL single_start_latency got=%0d required=%0d", (starts.size() > 0) ? starts[0] : -1, cn + 1);
    end
    tick(2);
    bus_rd(A_STAT, d, s);
    checks++; if (d !== 32'h4) begin errors++; $display("FAIL single_idle_status got=%h required=00000004", d); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d; logic s; int f0;
    bus_wr(A_DIV, 32'd2);
    starts.delete(); f0 = frames_done;
    sb.push_back('{8'hA5, 2}); sb.push_back('{8'h3C, 2}); sb.push_back('{8'hFF, 2});
    bus_wr(A_DATA, 32'hA5); bus_wr(A_DATA, 32'h3C); bus_wr(A_DATA, 32'hFF);
    bus_rd(A_STAT, d, s);
    checks++; if (d !== 32'h201) begin errors++; $display("FAIL b2b_count_status got=%h required=00000201", d); end
    wait_frames(f0 + 3, 200);
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (starts.size() < 3 || starts[i] - starts[i-1] != 20) begin
        errors++; $display("FAIL b2b_spacing idx=%0d got=%0d required=20", i, (starts.size() < 3) ? -1 : starts[i] - starts[i-1]);
      end
    end
    tick(2);
  endtask

  task automatic test_overflow;
    logic [31:0] d; logic s; int cn, f0;
    bus_wr(A_DIV, 32'd4);
    f0 = frames_done;
    for (int i = 0; i < 9; i++) begin
      sb.push_back('{8'(8'h10 + i), 4});
      bus_wr(A_DATA, 32'h10 + i);
      if (i == 0) cn = cyc;
    end
    bus_rd(A_STAT, d, s);
    checks++; if (d !== 32'h803) begin errors++; $display("FAIL ovf_full_status got=%h required=00000803", d); end
    bus_wr(A_DATA, 32'hEE);
    bus_rd(A_STAT, d, s);
    checks++; if (d !== 32'h80B) begin errors++; $display("FAIL ovf_set_status got=%h required=0000080b", d); end
    bus_wr(A_STAT, 32'h8);
    bus_rd(A_STAT, d, s);
    checks++; if (d !== 32'h803) begin errors++; $display("FAIL ovf_clear_status got=%h required=00000803", d); end
    // Second pop lands on edge cn+41; a push on that edge must be accepted
    while (cyc < cn + 40) tick(1);
    sb.push_back('{8'h77, 4});
    bus_wr(A_DATA, 32'h77);
    bus_rd(A_STAT, d, s);
    checks++; if (d !== 32'h803) begin errors++; $display("FAIL ovf_push_on_pop got=%h required=00000803", d); end
    wait_frames(f0 + 10, 500);
    tick(2);
  endtask

  task automatic test_div;
    logic [31:0] d; logic s; int f0;
    bus_wr(A_DIV, 32'd0);
    bus_rd(A_DIV, d, s);
    checks++; if (d !== 32'd2) begin errors++; $display("FAIL div_min_clamp got=%0d required=2", d); end
    bus_wr(A_DIV, 32'd4);
    starts.delete(); f0 = frames_done;
    sb.push_back('{8'hC3, 4}); sb.push_back('{8'h81, 8});
    bus_wr(A_DATA, 32'hC3); bus_wr(A_DATA, 32'h81);
    tick(5);
    bus_wr(A_DIV, 32'd8);
    bus_rd(A_DIV, d, s);
    checks++; if (d !== 32'd8) begin errors++; $display("FAIL div_readback got=%0d required=8", d); end
    wait_frames(f0 + 2, 300);
    checks++;
    if (starts.size() < 2 || starts[1] - starts[0] != 40) begin
      errors++; $display("FAIL div_old_frame_len got=%0d required=40", (starts.size() < 2) ? -1 : starts[1] - starts[0]);
    end
    tick(2);
  endtask

  task automatic test_decode;
    logic [31:0] d; logic s;
    bus_wr(BASE + 32'hC, 32'hFFFF_FFFF);
    bus_rd(BASE + 32'hC, d, s);
    checks++; if (s !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL dec_reserved sel=%b rdata=%h required sel=1 rdata=0", s, d); end
    bus_wr(BASE + 32'h2, 32'h33);
    bus_rd(BASE + 32'h2, d, s);
    checks++; if (s !== 1'b0 || d !== 32'h0) begin errors++; $display("FAIL dec_misaligned sel=%b rdata=%h required sel=0 rdata=0", s, d); end
    bus_wr(BASE + 32'h10, 32'h55);
    bus_rd(BASE + 32'h10, d, s);
    checks++; if (s !== 1'b0 || d !== 32'h0) begin errors++; $display("FAIL dec_outside sel=%b rdata=%h required sel=0 rdata=0", s, d); end
    tick(5);
    bus_rd(A_DIV, d, s);
    checks++; if (d !== 32'd8) begin errors++; $display("FAIL dec_div_kept got=%0d required=8", d); end
    bus_rd(A_STAT, d, s);
    checks++; if (d !== 32'h4) begin errors++; $display("FAIL dec_fifo_kept got=%h required=00000004", d); end
  endtask

  task automatic test_rst_mid;
    logic [31:0] d; logic s; int f0, lows;
    bus_wr(A_DIV, 32'd2);
    mon_abort = 1'b1;
    bus_wr(A_DATA, 32'h00); bus_wr(A_DATA, 32'h12); bus_wr(A_DATA, 32'h34);
    tick(6);
    rst = 1'b1; tick(1);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rst_mid_tx got=%b required=1", tx); end
    bus_rd(A_STAT, d, s);
    checks++; if (d !== 32'h4) begin errors++; $display("FAIL rst_mid_status got=%h required=00000004", d); end
    rst = 1'b0;
    bus_rd(A_DIV, d, s);
    checks++; if (d !== 32'd16) begin errors++; $display("FAIL rst_mid_div got=%0d required=16", d); end
    tick(1);
    mon_abort = 1'b0; f0 = frames_done; lows = 0;
    for (int i = 0; i < 100; i++) begin tick(1); if (tx !== 1'b1) lows++; end
    checks++; if (lows != 0) begin errors++; $display("FAIL rst_mid_quiet low_cycles=%0d required=0", lows); end
    checks++; if (frames_done != f0) begin errors++; $display("FAIL rst_mid_no_frames got=%0d required=%0d", frames_done, f0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_div();
    test_decode();
    test_rst_mid();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain left=%0d required=0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
